// File: rtl/qec_match_pe_pkg.sv
// qec_match_pe_pkg
//   Shared widths, message/status encodings, field offsets and a message
//   packing helper for the distributed matching decoder processing element.
//   Message format : {type[1:0], row, col, cost}
//   Match format   : {status[1:0], partner_row, partner_col}
package qec_match_pe_pkg;

   localparam int CORDINATE_WIDTH   = 4;
   localparam int COST_WIDTH        = 4;
   localparam int MSG_WIDTH         = 2 + 2*CORDINATE_WIDTH + COST_WIDTH;
   localparam int MATCH_VALUE_WIDTH = 2 + 2*CORDINATE_WIDTH;

   localparam int MSG_COST_LSB = 0;
   localparam int MSG_COL_LSB  = COST_WIDTH;
   localparam int MSG_ROW_LSB  = COST_WIDTH + CORDINATE_WIDTH;
   localparam int MSG_TYPE_LSB = COST_WIDTH + 2*CORDINATE_WIDTH;

   localparam logic [1:0] MSG_NONE   = 2'd0;
   localparam logic [1:0] MSG_OFFER  = 2'd1;
   localparam logic [1:0] MSG_ACCEPT = 2'd2;
   localparam logic [1:0] MSG_RSVD   = 2'd3;

   localparam logic [1:0] ST_NONE     = 2'd0;
   localparam logic [1:0] ST_MATCHED  = 2'd1;
   localparam logic [1:0] ST_BOUNDARY = 2'd2;
   localparam logic [1:0] ST_PENDING  = 2'd3;

   localparam logic [1:0] PH_IDLE   = 2'd0;
   localparam logic [1:0] PH_OFFER  = 2'd1;
   localparam logic [1:0] PH_ACCEPT = 2'd2;

   // Direction indices chosen so that the opposite direction is 3 - d.
   localparam int DIR_N = 0;
   localparam int DIR_E = 1;
   localparam int DIR_W = 2;
   localparam int DIR_S = 3;

   function automatic logic [MSG_WIDTH-1:0] msg_pack(
      input logic [1:0]                 mtype,
      input logic [CORDINATE_WIDTH-1:0] row,
      input logic [CORDINATE_WIDTH-1:0] col,
      input logic [COST_WIDTH-1:0]      cost);
      return {mtype, row, col, cost};
   endfunction

endpackage

// File: rtl/qec_pe_outqueue.sv
// qec_pe_outqueue
//   Two-entry valid/ready FIFO used for each outgoing direction.
//   push_valid_i/push_data_i/push_ready_o : write side (ready = space left)
//   pop_valid_o/pop_data_o/pop_ready_i    : read side, head held stable
module qec_pe_outqueue
   import qec_match_pe_pkg::*;
(
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 push_valid_i,
   input  logic [MSG_WIDTH-1:0] push_data_i,
   output logic                 push_ready_o,
   output logic                 pop_valid_o,
   output logic [MSG_WIDTH-1:0] pop_data_o,
   input  logic                 pop_ready_i
);

   logic [MSG_WIDTH-1:0] mem_q [2];
   logic                 rd_ptr_q;
   logic                 wr_ptr_q;
   logic [1:0]           count_q;
   logic                 push_fire;
   logic                 pop_fire;

   assign push_ready_o = (count_q != 2'd2);
   assign pop_valid_o  = (count_q != 2'd0);
   assign pop_data_o   = mem_q[rd_ptr_q];
   assign push_fire    = push_valid_i && push_ready_o;
   assign pop_fire     = pop_valid_o && pop_ready_i;

   always_ff @(posedge clk) begin
      if (reset) begin
         rd_ptr_q <= 1'b0;
         wr_ptr_q <= 1'b0;
         count_q  <= 2'd0;
      end else begin
         if (push_fire) wr_ptr_q <= ~wr_ptr_q;
         if (pop_fire)  rd_ptr_q <= ~rd_ptr_q;
         count_q <= count_q + 2'(push_fire) - 2'(pop_fire);
      end
   end

   // Storage carries no reset; occupancy alone decides what is visible.
   always_ff @(posedge clk) begin
      if (push_fire) mem_q[wr_ptr_q] <= push_data_i;
   end

endmodule

// File: rtl/qec_match_pe.sv
// qec_match_pe
//   One grid element of a distributed matching decoder. A pending defect
//   broadcasts OFFERs, keeps the cheapest incoming OFFER, and on stop_offer
//   either sends an ACCEPT toward it or falls back to the boundary. Any other
//   element relays messages straight through to the opposite side.
//   Ports: clk/reset, measurement load, start/stop round pulses,
//   match_value_out {status, partner_row, partner_col}, four valid/ready
//   mailbox inputs, four valid/ready outqueue outputs, static ROW_ID,
//   COL_ID and BOUNDARY_COST.
module qec_match_pe
   import qec_match_pe_pkg::*;
(
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         measurement_value_in,
   input  logic                         measurement_valid_in,
   input  logic                         start_offer,
   input  logic                         stop_offer,
   output logic [MATCH_VALUE_WIDTH-1:0] match_value_out,
   input  logic [MSG_WIDTH-1:0]         mailbox_north_value_in,
   input  logic                         mailbox_north_valid_in,
   output logic                         mailbox_north_ready_out,
   input  logic [MSG_WIDTH-1:0]         mailbox_east_value_in,
   input  logic                         mailbox_east_valid_in,
   output logic                         mailbox_east_ready_out,
   input  logic [MSG_WIDTH-1:0]         mailbox_west_value_in,
   input  logic                         mailbox_west_valid_in,
   output logic                         mailbox_west_ready_out,
   input  logic [MSG_WIDTH-1:0]         mailbox_south_value_in,
   input  logic                         mailbox_south_valid_in,
   output logic                         mailbox_south_ready_out,
   output logic [MSG_WIDTH-1:0]         outqueue_north_value_out,
   output logic                         outqueue_north_valid_out,
   input  logic                         outqueue_north_ready_in,
   output logic [MSG_WIDTH-1:0]         outqueue_east_value_out,
   output logic                         outqueue_east_valid_out,
   input  logic                         outqueue_east_ready_in,
   output logic [MSG_WIDTH-1:0]         outqueue_west_value_out,
   output logic                         outqueue_west_valid_out,
   input  logic                         outqueue_west_ready_in,
   output logic [MSG_WIDTH-1:0]         outqueue_south_value_out,
   output logic                         outqueue_south_valid_out,
   input  logic                         outqueue_south_ready_in,
   input  logic [CORDINATE_WIDTH-1:0]   ROW_ID,
   input  logic [CORDINATE_WIDTH-1:0]   COL_ID,
   input  logic [COST_WIDTH-1:0]        BOUNDARY_COST
);

   localparam int KEY_W = COST_WIDTH + 2*CORDINATE_WIDTH;

   logic [MSG_WIDTH-1:0] mb_value [4];
   logic [3:0]           mb_valid, mb_ready, mb_fire;
   logic [MSG_WIDTH-1:0] oq_value [4];
   logic [3:0]           oq_valid, oq_ready;
   logic [3:0]           fifo_space;
   logic [3:0]           push_vld;
   logic [MSG_WIDTH-1:0] push_msg [4];
   logic [3:0]           local_vld;
   logic [MSG_WIDTH-1:0] local_msg [4];

   logic                       defect_q, defect_d;
   logic [1:0]                 status_q, status_d;
   logic [1:0]                 phase_q, phase_d;
   logic [2*CORDINATE_WIDTH-1:0] partner_q, partner_d;
   logic [KEY_W-1:0]           best_key_q, best_key_d;
   logic [1:0]                 best_dir_q, best_dir_d;

   logic                 active, decide, take_accept, accept_hit, cand_vld;
   logic [KEY_W-1:0]     cand_key;
   logic [1:0]           cand_dir;
   logic [COST_WIDTH-1:0] best_cost;

   assign mb_value = '{mailbox_north_value_in, mailbox_east_value_in,
                       mailbox_west_value_in, mailbox_south_value_in};
   assign mb_valid = {mailbox_south_valid_in, mailbox_west_valid_in,
                      mailbox_east_valid_in, mailbox_north_valid_in};
   assign oq_ready = {outqueue_south_ready_in, outqueue_west_ready_in,
                      outqueue_east_ready_in, outqueue_north_ready_in};
   assign {mailbox_south_ready_out, mailbox_west_ready_out,
           mailbox_east_ready_out, mailbox_north_ready_out} = mb_ready;
   assign {outqueue_south_valid_out, outqueue_west_valid_out,
           outqueue_east_valid_out, outqueue_north_valid_out} = oq_valid;
   assign outqueue_north_value_out = oq_value[DIR_N];
   assign outqueue_east_value_out  = oq_value[DIR_E];
   assign outqueue_west_value_out  = oq_value[DIR_W];
   assign outqueue_south_value_out = oq_value[DIR_S];

   assign match_value_out = {status_q, partner_q};
   assign active          = defect_q && (status_q == ST_PENDING);
   assign best_cost       = best_key_q[KEY_W-1 -: COST_WIDTH];
   assign decide          = !measurement_valid_in && stop_offer &&
                            (phase_q == PH_OFFER) && active;
   assign take_accept     = decide && (best_cost < BOUNDARY_COST);

   // Relayed OFFERs pay one more hop (saturating); everything else passes unchanged.
   function automatic logic [MSG_WIDTH-1:0] relay_bump(input logic [MSG_WIDTH-1:0] m);
      logic [MSG_WIDTH-1:0] r;
      r = m;
      if (m[MSG_TYPE_LSB +: 2] == MSG_OFFER && m[MSG_COST_LSB +: COST_WIDTH] != '1)
         r[MSG_COST_LSB +: COST_WIDTH] = m[MSG_COST_LSB +: COST_WIDTH] + 1'b1;
      return r;
   endfunction

   // Locally generated messages: ACCEPT toward the best offer, or the OFFER broadcast.
   always_comb begin
      local_vld = '0;
      for (int d = 0; d < 4; d++) local_msg[d] = '0;
      if (!reset) begin
         if (take_accept) begin
            local_vld[best_dir_q] = 1'b1;
            local_msg[best_dir_q] = msg_pack(MSG_ACCEPT, ROW_ID, COL_ID, best_cost);
         end else if (!measurement_valid_in && start_offer && !stop_offer && active) begin
            for (int d = 0; d < 4; d++) begin
               local_vld[d] = 1'b1;
               local_msg[d] = msg_pack(MSG_OFFER, ROW_ID, COL_ID, COST_WIDTH'(1));
            end
         end
      end
   end

   // An active element absorbs everything; otherwise a mailbox is ready only
   // if the opposite queue has room and is not taken by a local message.
   always_comb begin
      for (int d = 0; d < 4; d++) begin
         mb_ready[d] = !reset && (active || (fifo_space[3-d] && !local_vld[3-d]));
         mb_fire[d]  = mb_valid[d] && mb_ready[d];
      end
      for (int t = 0; t < 4; t++) begin
         push_vld[t] = local_vld[t] || (!active && mb_fire[3-t]);
         push_msg[t] = local_vld[t] ? local_msg[t] : relay_bump(mb_value[3-t]);
      end
   end

   // Cheapest absorbed OFFER this cycle; key {cost,row,col} gives the tie order.
   always_comb begin
      cand_vld   = 1'b0;
      cand_key   = '1;
      cand_dir   = 2'd0;
      accept_hit = 1'b0;
      for (int d = 0; d < 4; d++) begin
         if (active && mb_fire[d]) begin
            if (mb_value[d][MSG_TYPE_LSB +: 2] == MSG_OFFER &&
                (!cand_vld || {mb_value[d][MSG_COST_LSB +: COST_WIDTH],
                               mb_value[d][MSG_COL_LSB +: 2*CORDINATE_WIDTH]} < cand_key)) begin
               cand_vld = 1'b1;
               cand_key = {mb_value[d][MSG_COST_LSB +: COST_WIDTH],
                           mb_value[d][MSG_COL_LSB +: 2*CORDINATE_WIDTH]};
               cand_dir = 2'(d);
            end
            if (mb_value[d][MSG_TYPE_LSB +: 2] == MSG_ACCEPT &&
                mb_value[d][MSG_COL_LSB +: 2*CORDINATE_WIDTH] ==
                best_key_q[2*CORDINATE_WIDTH-1:0])
               accept_hit = 1'b1;
         end
      end
   end

   always_comb begin
      defect_d   = defect_q;
      status_d   = status_q;
      phase_d    = phase_q;
      partner_d  = partner_q;
      best_key_d = best_key_q;
      best_dir_d = best_dir_q;
      if (measurement_valid_in) begin
         defect_d   = measurement_value_in;
         status_d   = measurement_value_in ? ST_PENDING : ST_NONE;
         phase_d    = PH_IDLE;
         partner_d  = '0;
         best_key_d = '1;
      end else if (stop_offer) begin
         if (take_accept) begin
            phase_d = PH_ACCEPT;
         end else if (decide) begin
            status_d  = ST_BOUNDARY;
            partner_d = {ROW_ID, COL_ID};
            phase_d   = PH_IDLE;
         end
      end else if (start_offer) begin
         phase_d    = PH_OFFER;
         best_key_d = '1;
      end else begin
         if (phase_q == PH_OFFER && cand_vld && cand_key < best_key_q) begin
            best_key_d = cand_key;
            best_dir_d = cand_dir;
         end
         if (phase_q == PH_ACCEPT && accept_hit) begin
            status_d  = ST_MATCHED;
            partner_d = best_key_q[2*CORDINATE_WIDTH-1:0];
            phase_d   = PH_IDLE;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         defect_q   <= 1'b0;
         status_q   <= ST_NONE;
         phase_q    <= PH_IDLE;
         partner_q  <= '0;
         best_key_q <= '1;
         best_dir_q <= 2'd0;
      end else begin
         defect_q   <= defect_d;
         status_q   <= status_d;
         phase_q    <= phase_d;
         partner_q  <= partner_d;
         best_key_q <= best_key_d;
         best_dir_q <= best_dir_d;
      end
   end

   for (genvar g = 0; g < 4; g++) begin : g_oq
      qec_pe_outqueue u_oq (
         .clk          (clk),
         .reset        (reset),
         .push_valid_i (push_vld[g]),
         .push_data_i  (push_msg[g]),
         .push_ready_o (fifo_space[g]),
         .pop_valid_o  (oq_valid[g]),
         .pop_data_o   (oq_value[g]),
         .pop_ready_i  (oq_ready[g])
      );
   end

endmodule

// File: tb/tb_qec_match_pe.sv
module tb_qec_match_pe;
   import qec_match_pe_pkg::*;

   logic clk = 1'b0;
   logic reset;
   logic meas_val, meas_vld, start_offer, stop_offer;
   logic [MATCH_VALUE_WIDTH-1:0] match_value;
   logic [MSG_WIDTH-1:0] mb_n_v, mb_e_v, mb_w_v, mb_s_v;
   logic mb_n_vld, mb_e_vld, mb_w_vld, mb_s_vld;
   logic mb_n_rdy, mb_e_rdy, mb_w_rdy, mb_s_rdy;
   logic [MSG_WIDTH-1:0] oq_n_v, oq_e_v, oq_w_v, oq_s_v;
   logic oq_n_vld, oq_e_vld, oq_w_vld, oq_s_vld;
   logic oq_n_rdy, oq_e_rdy, oq_w_rdy, oq_s_rdy;
   logic [CORDINATE_WIDTH-1:0] row_id, col_id;
   logic [COST_WIDTH-1:0] bcost;

   int n_cmp = 0;
   int n_mis = 0;

   always #5 clk = ~clk;

   qec_match_pe dut (
      .clk(clk), .reset(reset),
      .measurement_value_in(meas_val), .measurement_valid_in(meas_vld),
      .start_offer(start_offer), .stop_offer(stop_offer),
      .match_value_out(match_value),
      .mailbox_north_value_in(mb_n_v), .mailbox_north_valid_in(mb_n_vld), .mailbox_north_ready_out(mb_n_rdy),
      .mailbox_east_value_in(mb_e_v),  .mailbox_east_valid_in(mb_e_vld),  .mailbox_east_ready_out(mb_e_rdy),
      .mailbox_west_value_in(mb_w_v),  .mailbox_west_valid_in(mb_w_vld),  .mailbox_west_ready_out(mb_w_rdy),
      .mailbox_south_value_in(mb_s_v), .mailbox_south_valid_in(mb_s_vld), .mailbox_south_ready_out(mb_s_rdy),
      .outqueue_north_value_out(oq_n_v), .outqueue_north_valid_out(oq_n_vld), .outqueue_north_ready_in(oq_n_rdy),
      .outqueue_east_value_out(oq_e_v),  .outqueue_east_valid_out(oq_e_vld),  .outqueue_east_ready_in(oq_e_rdy),
      .outqueue_west_value_out(oq_w_v),  .outqueue_west_valid_out(oq_w_vld),  .outqueue_west_ready_in(oq_w_rdy),
      .outqueue_south_value_out(oq_s_v), .outqueue_south_valid_out(oq_s_vld), .outqueue_south_ready_in(oq_s_rdy),
      .ROW_ID(row_id), .COL_ID(col_id), .BOUNDARY_COST(bcost)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_mis++;
         $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [MSG_WIDTH-1:0] m(input int t, input int r, input int c, input int k);
      return {2'(t), 4'(r), 4'(c), 4'(k)};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load(input logic v);
      meas_val = v; meas_vld = 1'b1;
      tick();
      meas_vld = 1'b0;
   endtask

   task automatic set_oq_rdy(input logic v);
      oq_n_rdy = v; oq_e_rdy = v; oq_w_rdy = v; oq_s_rdy = v;
   endtask

   initial begin
      reset = 1'b1; meas_val = 0; meas_vld = 0; start_offer = 0; stop_offer = 0;
      mb_n_v = '0; mb_e_v = '0; mb_w_v = '0; mb_s_v = '0;
      mb_n_vld = 0; mb_e_vld = 0; mb_w_vld = 0; mb_s_vld = 0;
      set_oq_rdy(1'b1);
      row_id = 4'd4; col_id = 4'd2; bcost = 4'd6;

      // Reset
      tick(); tick(); tick();
      chk("rst_ready_low", {mb_n_rdy, mb_e_rdy, mb_w_rdy, mb_s_rdy}, 4'b0000);
      reset = 1'b0;
      tick();
      chk("rst_valid_out", {oq_n_vld, oq_e_vld, oq_w_vld, oq_s_vld}, 4'b0000);
      chk("rst_match", match_value, 10'h000);
      chk("rst_ready_high", {mb_n_rdy, mb_e_rdy, mb_w_rdy, mb_s_rdy}, 4'b1111);

      // Offer broadcast with hold then drain
      set_oq_rdy(1'b0);
      load(1'b1);
      chk("pending_status", match_value, 10'h300);
      start_offer = 1'b1; tick(); start_offer = 1'b0;
      chk("bcast_valid", {oq_n_vld, oq_e_vld, oq_w_vld, oq_s_vld}, 4'b1111);
      chk("bcast_n", oq_n_v, m(1,4,2,1));
      chk("bcast_w", oq_w_v, m(1,4,2,1));
      tick();
      chk("bcast_hold", oq_e_v, m(1,4,2,1));
      chk("bcast_hold_vld", oq_e_vld, 1'b1);
      oq_s_rdy = 1'b1; tick();
      chk("bcast_drain_s", {oq_n_vld, oq_s_vld}, 2'b10);
      set_oq_rdy(1'b1); tick();
      chk("bcast_drained", {oq_n_vld, oq_e_vld, oq_w_vld, oq_s_vld}, 4'b0000);

      // Relay
      load(1'b0);
      mb_n_v = m(1,1,2,3); mb_n_vld = 1'b1; #1;
      chk("relay_rdy", mb_n_rdy, 1'b1);
      tick(); mb_n_vld = 1'b0;
      chk("relay_s_vld", oq_s_vld, 1'b1);
      chk("relay_s_val", oq_s_v, m(1,1,2,4));
      chk("relay_n_empty", oq_n_vld, 1'b0);
      tick();
      oq_s_rdy = 1'b0;
      mb_n_v = m(1,3,3,2); mb_n_vld = 1'b1; tick();
      mb_n_v = m(1,5,6,7); tick();
      chk("relay_full_rdy", mb_n_rdy, 1'b0);
      chk("relay_full_head", oq_s_v, m(1,3,3,3));
      mb_n_vld = 1'b0; oq_s_rdy = 1'b1; tick();
      chk("relay_second", oq_s_v, m(1,5,6,8));
      tick();
      chk("relay_empty", oq_s_vld, 1'b0);
      mb_n_v = m(1,7,7,15); mb_n_vld = 1'b1; tick(); mb_n_vld = 1'b0;
      chk("relay_sat", oq_s_v, m(1,7,7,15));
      mb_e_v = m(2,1,2,5); mb_e_vld = 1'b1; tick(); mb_e_vld = 1'b0;
      chk("relay_accept", oq_w_v, m(2,1,2,5));
      tick();

      // Match with same-cycle tie break
      load(1'b1);
      start_offer = 1'b1; tick(); start_offer = 1'b0;
      mb_n_v = m(1,1,2,3); mb_n_vld = 1'b1;
      mb_e_v = m(1,4,5,3); mb_e_vld = 1'b1; #1;
      chk("absorb_rdy", {mb_n_rdy, mb_e_rdy}, 2'b11);
      tick(); mb_n_vld = 1'b0; mb_e_vld = 1'b0;
      chk("absorb_no_relay", {oq_s_vld, oq_w_vld}, 2'b00);
      stop_offer = 1'b1; tick(); stop_offer = 1'b0;
      chk("accept_vld", {oq_n_vld, oq_e_vld, oq_w_vld, oq_s_vld}, 4'b1000);
      chk("accept_val", oq_n_v, m(2,4,2,3));
      mb_e_v = m(2,4,5,3); mb_e_vld = 1'b1; tick(); mb_e_vld = 1'b0;
      chk("wrong_accept", match_value, 10'h300);
      mb_n_v = m(2,1,2,3); mb_n_vld = 1'b1; tick(); mb_n_vld = 1'b0;
      chk("matched", match_value, 10'h112);

      // Boundary fallback
      load(1'b1);
      start_offer = 1'b1; tick(); start_offer = 1'b0;
      mb_n_v = m(1,1,2,6); mb_n_vld = 1'b1; tick(); mb_n_vld = 1'b0;
      stop_offer = 1'b1; tick(); stop_offer = 1'b0;
      chk("boundary", match_value, 10'h242);
      chk("boundary_no_acc", {oq_n_vld, oq_e_vld, oq_w_vld, oq_s_vld}, 4'b0000);

      // start and stop together: start ignored
      load(1'b1);
      start_offer = 1'b1; stop_offer = 1'b1; tick();
      start_offer = 1'b0; stop_offer = 1'b0;
      chk("start_stop", {oq_n_vld, oq_e_vld, oq_w_vld, oq_s_vld}, 4'b0000);
      chk("start_stop_st", match_value, 10'h300);

      // Reset mid-round
      set_oq_rdy(1'b0);
      start_offer = 1'b1; tick(); start_offer = 1'b0;
      chk("mid_queued", oq_n_vld, 1'b1);
      reset = 1'b1; #1;
      chk("mid_rst_rdy", {mb_n_rdy, mb_e_rdy, mb_w_rdy, mb_s_rdy}, 4'b0000);
      tick();
      chk("mid_rst_vld", {oq_n_vld, oq_e_vld, oq_w_vld, oq_s_vld}, 4'b0000);
      chk("mid_rst_match", match_value, 10'h000);
      reset = 1'b0; tick();
      chk("mid_rel_rdy", {mb_n_rdy, mb_e_rdy, mb_w_rdy, mb_s_rdy}, 4'b1111);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
